// File: rtl/inst_fetcher.sv
// inst_fetcher: PC plus direct-mapped one-word-line icache feeding issue, misses go to the memory controller
module inst_fetcher #(
    parameter int          ICACHE_IDX_W = 8,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic [31:0] pc_to_mem,
    output logic        en_to_mem,
    output logic        drop_flag_to_mem,
    input  logic        ok_flag_from_mem,
    input  logic [31:0] inst_from_mem,
    input  logic        issue_full_from_rs,
    output logic        inst_valid_to_issue,
    output logic [31:0] inst_to_issue,
    output logic [31:0] pc_to_issue,
    input  logic        rollback_flag_from_rob,
    input  logic [31:0] target_pc_from_rob
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic {S_LOOKUP, S_WAIT} state_t;

    state_t                  r_state;
    logic [31:0]             r_pc;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag [LINES];
    logic [31:0]             r_data [LINES];

    state_t                  w_next_state;
    logic [ICACHE_IDX_W-1:0] w_idx;
    logic [ICACHE_IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [TAG_W-1:0]        w_fill_tag;
    logic                    w_hit;
    logic                    w_issue;
    logic                    w_miss;
    logic                    w_fill;

    assign drop_flag_to_mem = rollback_flag_from_rob;

    // lookup decode and next state; rollback overrides everything
    always_comb begin
        w_idx        = r_pc[ICACHE_IDX_W+1:2];
        w_tag        = r_pc[31:ICACHE_IDX_W+2];
        w_fill_idx   = pc_to_mem[ICACHE_IDX_W+1:2];
        w_fill_tag   = pc_to_mem[31:ICACHE_IDX_W+2];
        w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_issue      = (r_state == S_LOOKUP) && w_hit && !issue_full_from_rs && !rollback_flag_from_rob;
        w_miss       = (r_state == S_LOOKUP) && !w_hit && !rollback_flag_from_rob;
        w_fill       = (r_state == S_WAIT) && ok_flag_from_mem && !rollback_flag_from_rob;
        w_next_state = rollback_flag_from_rob ? S_LOOKUP :
                       w_miss                 ? S_WAIT   :
                       w_fill                 ? S_LOOKUP : r_state;
    end

    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= S_LOOKUP;
        else if (rdy_in)
            r_state <= w_next_state;
    end

    // pc, valid bits and registered outputs; request and issue are single-cycle pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc                <= RESET_PC & ~32'd3;
            r_valid             <= '0;
            en_to_mem           <= 1'b0;
            pc_to_mem           <= '0;
            inst_valid_to_issue <= 1'b0;
            inst_to_issue       <= '0;
            pc_to_issue         <= '0;
        end else if (rdy_in) begin
            en_to_mem           <= w_miss;
            inst_valid_to_issue <= w_issue;
            if (w_miss)
                pc_to_mem <= r_pc;
            if (w_issue) begin
                inst_to_issue <= r_data[w_idx];
                pc_to_issue   <= r_pc;
            end
            if (rollback_flag_from_rob)
                r_pc <= target_pc_from_rob & ~32'd3;
            else if (w_issue)
                r_pc <= r_pc + 32'd4;
            if (w_fill)
                r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // line data and tag storage, written only by a fill; valid bits gate their use
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_fill) begin
            r_data[w_fill_idx] <= inst_from_mem;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed scenario tests for the fetch stage and icache
module tb_inst_fetcher;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [31:0] pc_to_mem;
    logic        en_to_mem;
    logic        drop_flag_to_mem;
    logic        ok_flag_from_mem = 1'b0;
    logic [31:0] inst_from_mem = '0;
    logic        issue_full_from_rs = 1'b0;
    logic        inst_valid_to_issue;
    logic [31:0] inst_to_issue;
    logic [31:0] pc_to_issue;
    logic        rollback_flag_from_rob = 1'b0;
    logic [31:0] target_pc_from_rob = '0;

    int tests = 0;
    int fails = 0;

    inst_fetcher #(.ICACHE_IDX_W(8), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pc_to_mem(pc_to_mem), .en_to_mem(en_to_mem), .drop_flag_to_mem(drop_flag_to_mem),
        .ok_flag_from_mem(ok_flag_from_mem), .inst_from_mem(inst_from_mem),
        .issue_full_from_rs(issue_full_from_rs),
        .inst_valid_to_issue(inst_valid_to_issue), .inst_to_issue(inst_to_issue), .pc_to_issue(pc_to_issue),
        .rollback_flag_from_rob(rollback_flag_from_rob), .target_pc_from_rob(target_pc_from_rob)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00000013 : (a ^ 32'hDEAD0000);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        rollback_flag_from_rob = 1'b1;
        target_pc_from_rob = t;
        tick();
        rollback_flag_from_rob = 1'b0;
    endtask

    // waits (bounded) for the miss request at a, answers 4 cycles later, then expects the issue
    task automatic serve(input logic [31:0] a);
        int n = 0;
        while (!en_to_mem && n < 8) begin
            tick();
            n++;
        end
        tests++;
        if (en_to_mem !== 1'b1 || pc_to_mem !== a) begin
            fails++;
            $display("FAIL serve_req en=%b pc_to_mem=%h exp en=1 pc_to_mem=%h", en_to_mem, pc_to_mem, a);
        end
        repeat (3) tick();
        tests++;
        if (en_to_mem !== 1'b0) begin
            fails++;
            $display("FAIL serve_no_resend en=%b exp 0", en_to_mem);
        end
        ok_flag_from_mem = 1'b1;
        inst_from_mem = mem_word(a);
        tick();
        ok_flag_from_mem = 1'b0;
        tests++;
        if (inst_valid_to_issue !== 1'b0) begin
            fails++;
            $display("FAIL serve_fill_cycle valid=%b exp 0", inst_valid_to_issue);
        end
        tick();
        tests++;
        if (inst_valid_to_issue !== 1'b1 || inst_to_issue !== mem_word(a) || pc_to_issue !== a) begin
            fails++;
            $display("FAIL serve_issue valid=%b inst=%h pc=%h exp 1 %h %h",
                     inst_valid_to_issue, inst_to_issue, pc_to_issue, mem_word(a), a);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) tick();
        tests++;
        if ({en_to_mem, inst_valid_to_issue} !== 2'b00 || pc_to_mem !== 32'h0 ||
            inst_to_issue !== 32'h0 || pc_to_issue !== 32'h0) begin
            fails++;
            $display("FAIL reset en=%b valid=%b pcm=%h inst=%h pci=%h exp all 0",
                     en_to_mem, inst_valid_to_issue, pc_to_mem, inst_to_issue, pc_to_issue);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_cold_miss();
        tick();
        tests++;
        if (en_to_mem !== 1'b1 || pc_to_mem !== 32'h0) begin
            fails++;
            $display("FAIL cold_req en=%b pc_to_mem=%h exp 1 0", en_to_mem, pc_to_mem);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (en_to_mem !== 1'b0 || inst_valid_to_issue !== 1'b0) begin
                fails++;
                $display("FAIL cold_wait en=%b valid=%b exp 0 0", en_to_mem, inst_valid_to_issue);
            end
        end
        ok_flag_from_mem = 1'b1;
        inst_from_mem = 32'h00000013;
        tick();
        ok_flag_from_mem = 1'b0;
        tick();
        tests++;
        if (inst_valid_to_issue !== 1'b1 || inst_to_issue !== 32'h13 || pc_to_issue !== 32'h0) begin
            fails++;
            $display("FAIL cold_issue valid=%b inst=%h pc=%h exp 1 00000013 0",
                     inst_valid_to_issue, inst_to_issue, pc_to_issue);
        end
    endtask

    task automatic test_loop();
        serve(32'h4);
        serve(32'h8);
        serve(32'hC);
        redirect(32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (inst_valid_to_issue !== 1'b1 || pc_to_issue !== 32'(i * 4) ||
                inst_to_issue !== mem_word(32'(i * 4)) || en_to_mem !== 1'b0) begin
                fails++;
                $display("FAIL loop_hit valid=%b pc=%h inst=%h en=%b exp 1 %h %h 0",
                         inst_valid_to_issue, pc_to_issue, inst_to_issue, en_to_mem,
                         32'(i * 4), mem_word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_stall();
        issue_full_from_rs = 1'b1;
        redirect(32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (inst_valid_to_issue !== 1'b0 || en_to_mem !== 1'b0) begin
                fails++;
                $display("FAIL stall valid=%b en=%b exp 0 0", inst_valid_to_issue, en_to_mem);
            end
        end
        issue_full_from_rs = 1'b0;
        tick();
        tests++;
        if (inst_valid_to_issue !== 1'b1 || pc_to_issue !== 32'h8 || inst_to_issue !== mem_word(32'h8)) begin
            fails++;
            $display("FAIL stall_release valid=%b pc=%h inst=%h exp 1 00000008 %h",
                     inst_valid_to_issue, pc_to_issue, inst_to_issue, mem_word(32'h8));
        end
    endtask

    task automatic test_rollback();
        redirect(32'h40);
        tick();
        tests++;
        if (en_to_mem !== 1'b1 || pc_to_mem !== 32'h40 || drop_flag_to_mem !== 1'b0) begin
            fails++;
            $display("FAIL rb_req en=%b pcm=%h drop=%b exp 1 00000040 0", en_to_mem, pc_to_mem, drop_flag_to_mem);
        end
        repeat (2) tick();
        rollback_flag_from_rob = 1'b1;
        target_pc_from_rob = 32'h102;
        ok_flag_from_mem = 1'b1;
        inst_from_mem = mem_word(32'h40);
        #1;
        tests++;
        if (drop_flag_to_mem !== 1'b1) begin
            fails++;
            $display("FAIL rb_drop drop=%b exp 1", drop_flag_to_mem);
        end
        tick();
        rollback_flag_from_rob = 1'b0;
        ok_flag_from_mem = 1'b0;
        tests++;
        if (inst_valid_to_issue !== 1'b0 || en_to_mem !== 1'b0) begin
            fails++;
            $display("FAIL rb_cycle valid=%b en=%b exp 0 0", inst_valid_to_issue, en_to_mem);
        end
        serve(32'h100);
        redirect(32'h40);
        serve(32'h40);
    endtask

    task automatic test_conflict();
        test_reset();
        serve(32'h0);
        redirect(32'h400);
        serve(32'h400);
        redirect(32'h0);
        serve(32'h0);
    endtask

    task automatic test_rdy_hold();
        redirect(32'h80);
        tick();
        tests++;
        if (en_to_mem !== 1'b1 || pc_to_mem !== 32'h80) begin
            fails++;
            $display("FAIL rdy_req en=%b pcm=%h exp 1 00000080", en_to_mem, pc_to_mem);
        end
        tick();
        rdy_in = 1'b0;
        ok_flag_from_mem = 1'b1;
        inst_from_mem = 32'hBADBAD00;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (en_to_mem !== 1'b0 || inst_valid_to_issue !== 1'b0 || pc_to_mem !== 32'h80) begin
                fails++;
                $display("FAIL rdy_hold en=%b valid=%b pcm=%h exp 0 0 00000080",
                         en_to_mem, inst_valid_to_issue, pc_to_mem);
            end
            if (i == 2) begin
                rollback_flag_from_rob = 1'b1;
                #1;
                tests++;
                if (drop_flag_to_mem !== 1'b1) begin
                    fails++;
                    $display("FAIL rdy_drop drop=%b exp 1", drop_flag_to_mem);
                end
                rollback_flag_from_rob = 1'b0;
            end
        end
        rdy_in = 1'b1;
        issue_full_from_rs = 1'b1;
        inst_from_mem = mem_word(32'h80);
        tick();
        ok_flag_from_mem = 1'b0;
        tick();
        tests++;
        if (inst_valid_to_issue !== 1'b0 || en_to_mem !== 1'b0) begin
            fails++;
            $display("FAIL full_fill valid=%b en=%b exp 0 0", inst_valid_to_issue, en_to_mem);
        end
        issue_full_from_rs = 1'b0;
        tick();
        tests++;
        if (inst_valid_to_issue !== 1'b1 || pc_to_issue !== 32'h80 || inst_to_issue !== mem_word(32'h80)) begin
            fails++;
            $display("FAIL rdy_issue valid=%b pc=%h inst=%h exp 1 00000080 %h",
                     inst_valid_to_issue, pc_to_issue, inst_to_issue, mem_word(32'h80));
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_loop();
        test_stall();
        test_rollback();
        test_conflict();
        test_rdy_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
